// File: rtl/rep_seq_pkg.sv
// Shared types and constants for the a/b/c repetition stimulus generator.
package rep_seq_pkg;

   localparam int CNT_W = 3;  // b repetition counter width
   localparam int GAP_W = 2;  // inter-pulse gap counter width

   typedef enum logic [2:0] {
      IDLE,
      A_PULSE,
      SETTLE,
      B_ON,
      B_GAP,
      C_PULSE,
      DONE
   } state_t;

   typedef enum logic {
      CONSEC = 1'b0,
      GAPPED = 1'b1
   } mode_t;

   // Registered output bundle, one flop per output.
   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic busy;
      logic done;
   } out_t;

   // Counters hold "remaining after this one", so load effective value minus one;
   // a programmed zero behaves like one.
   function automatic logic [CNT_W-1:0] rep_reload(input logic [CNT_W-1:0] n);
      return (n == '0) ? '0 : n - 1'b1;
   endfunction

   function automatic logic [GAP_W-1:0] gap_reload(input logic [GAP_W-1:0] g);
      return (g == '0) ? '0 : g - 1'b1;
   endfunction

endpackage

// File: rtl/rep_seq_cnt.sv
// Loadable saturating down-counter with a zero flag.
module rep_seq_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // Load has priority; decrement stops at zero so the count never wraps.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rep_seq_gen.sv
// Generates one a / b-repeated / c stimulus sequence per accepted start.
module rep_seq_gen
   import rep_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] b_count,
   input  logic [GAP_W-1:0] gap,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic             done
);

   state_t           state, state_next;
   out_t             out_q, out_next;
   mode_t            mode_q;
   logic [GAP_W-1:0] gap_q;   // effective gap minus one
   logic             accept;
   logic             rep_load, rep_dec, rep_zero;
   logic             gap_load, gap_dec, gap_zero;

   assign accept = (state == IDLE) && start;

   rep_seq_cnt #(.W(CNT_W)) u_rep_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (rep_load),
      .load_val (rep_reload(b_count)),
      .dec      (rep_dec),
      .zero     (rep_zero)
   );

   rep_seq_cnt #(.W(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (gap_q),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   // State and output registers; outputs are decoded from the next state so they are flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out_q <= '0;
      end else begin
         state <= state_next;
         out_q <= out_next;
      end
   end

   // Capture configuration on start acceptance so later input changes cannot disturb the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= CONSEC;
         gap_q  <= '0;
      end else if (accept) begin
         mode_q <= mode_t'(mode);
         gap_q  <= gap_reload(gap);
      end
   end

   // Next-state and counter control.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      rep_load   = 1'b0;
      rep_dec    = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = A_PULSE;
               rep_load   = 1'b1;
            end
         end
         A_PULSE: state_next = SETTLE;
         SETTLE:  state_next = B_ON;
         B_ON: begin
            if (rep_zero) begin
               state_next = C_PULSE;
            end else begin
               rep_dec = 1'b1;
               if (mode_q == GAPPED) begin
                  state_next = B_GAP;
                  gap_load   = 1'b1;
               end
            end
         end
         B_GAP: begin
            if (gap_zero) begin
               state_next = B_ON;
            end else begin
               gap_dec = 1'b1;
            end
         end
         C_PULSE: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode of the state being entered; a, b and c are mutually exclusive by construction.
   always_comb begin
      out_next = '0;
      case (state_next)
         A_PULSE: begin
            out_next.a    = 1'b1;
            out_next.busy = 1'b1;
         end
         SETTLE: out_next.busy = 1'b1;
         B_ON: begin
            out_next.b    = 1'b1;
            out_next.busy = 1'b1;
         end
         B_GAP: out_next.busy = 1'b1;
         C_PULSE: begin
            out_next.c    = 1'b1;
            out_next.busy = 1'b1;
         end
         DONE:    out_next.done = 1'b1;
         default: out_next = '0;
      endcase
   end

   assign a    = out_q.a;
   assign b    = out_q.b;
   assign c    = out_q.c;
   assign busy = out_q.busy;
   assign done = out_q.done;

endmodule

// File: tb/tb_rep_seq_gen.sv
// Directed bench for rep_seq_gen: per-cycle scoreboard of {a,b,c,busy,done} plus
// repetition-property checks evaluated on the observed b trace.
module tb_rep_seq_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       mode;
   logic [2:0] b_count;
   logic [1:0] gap;
   logic       a, b, c, busy, done;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [4:0] sb[$];      // expected {a,b,c,busy,done} for upcoming cycles
   bit         b_trace[$]; // b from two cycles after a up to the cycle before c
   bit         tracing     = 0;
   bit         trace_done  = 0;
   int         since_a     = 0;

   rep_seq_gen dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .b_count (b_count),
      .gap     (gap),
      .a       (a),
      .b       (b),
      .c       (c),
      .busy    (busy),
      .done    (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected output vectors for one accepted start, from cycle 1 to the done cycle.
   task automatic push_seq(input bit md, input logic [2:0] bc, input logic [1:0] gp);
      int n, g;
      n = (bc == 0) ? 1 : int'(bc);
      g = (gp == 0) ? 1 : int'(gp);
      sb.push_back(5'b10010);                    // a
      sb.push_back(5'b00010);                    // settle
      for (int i = 0; i < n; i++) begin
         sb.push_back(5'b01010);                 // b
         if (md && (i < n - 1)) begin
            for (int k = 0; k < g; k++) sb.push_back(5'b00010);
         end
      end
      sb.push_back(5'b00110);                    // c
      sb.push_back(5'b00001);                    // done
   endtask

   // One clock cycle: check this cycle's outputs, update the model, then drive this cycle's inputs.
   task automatic step(input bit st, input bit md, input logic [2:0] bc, input logic [1:0] gp,
                       input bit rs);
      logic [4:0] exp_v, obs_v;
      bit         idle;
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 5'b00000;
      obs_v = {a, b, c, busy, done};
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL outputs cycle %0d: observed abc_busy_done=%b expected %b", cyc, obs_v, exp_v);
      end
      vectors++;
      assert (($countones(obs_v[4:2]) <= 1) === 1'b1) else begin
         miscompares++;
         $error("FAIL abc_exclusive cycle %0d: observed abc=%b expected at most one high", cyc, obs_v[4:2]);
      end
      // Observed b trace for the repetition properties.
      if (obs_v[4]) begin
         b_trace.delete();
         tracing    = 1;
         trace_done = 0;
         since_a    = 0;
      end else if (tracing) begin
         since_a++;
         if (obs_v[2]) begin
            tracing    = 0;
            trace_done = 1;
         end else if (since_a >= 2) begin
            b_trace.push_back(obs_v[3]);
         end
      end
      idle = (sb.size() == 0) && !exp_v[0];
      if (rs) begin
         sb.delete();
         tracing = 0;
      end else if (st && idle) begin
         push_seq(md, bc, gp);
      end
      start   = st;
      mode    = md;
      b_count = bc;
      gap     = gp;
      rst     = rs;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, 2'd0, 0);
   endtask

   // $rose(a) |=> ##1 b[*n] ##1 c
   function automatic bit prop_consec(input int n);
      int ones = 0;
      if (!trace_done) return 0;
      foreach (b_trace[i]) ones += int'(b_trace[i]);
      return (b_trace.size() == n) && (ones == n);
   endfunction

   // $rose(a) |=> ##1 b[=n] ##1 c
   function automatic bit prop_nonconsec(input int n);
      int ones = 0;
      if (!trace_done) return 0;
      foreach (b_trace[i]) ones += int'(b_trace[i]);
      return (ones == n);
   endfunction

   // $rose(a) |=> ##1 b[->m:n] ##1 c
   function automatic bit prop_goto(input int m, input int n);
      int ones = 0;
      if (!trace_done || (b_trace.size() == 0)) return 0;
      foreach (b_trace[i]) ones += int'(b_trace[i]);
      return (ones >= m) && (ones <= n) && b_trace[b_trace.size()-1];
   endfunction

   task automatic check_prop(input string tag, input bit obs, input bit exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] rbc;
      logic [1:0] rgp;
      bit         rmd;
      rst     = 1'b1;
      start   = 1'b0;
      mode    = 1'b0;
      b_count = 3'd0;
      gap     = 2'd0;

      // Reset held, then released; outputs must be all zero.
      step(0, 0, 3'd0, 2'd0, 1);
      step(0, 0, 3'd0, 2'd0, 1);
      step(0, 0, 3'd0, 2'd0, 0);
      idle_cycles(2);

      // CONSEC N=3: a@1, b@3..5, c@6, done@7.
      step(1, 0, 3'd3, 2'd0, 0);
      idle_cycles(10);
      check_prop("consec3_b_rep3", prop_consec(3), 1'b1);
      check_prop("consec3_goto2_4", prop_goto(2, 4), 1'b1);

      // GAPPED N=2 G=1: b@3,5, c@6.
      step(1, 1, 3'd2, 2'd1, 0);
      idle_cycles(10);
      check_prop("gap21_b_rep3", prop_consec(3), 1'b0);
      check_prop("gap21_b_nonconsec2", prop_nonconsec(2), 1'b1);
      check_prop("gap21_b_goto2_4", prop_goto(2, 4), 1'b1);

      // GAPPED N=4 G=3: b@3,7,11,15, c@16, done@17.
      step(1, 1, 3'd4, 2'd3, 0);
      idle_cycles(20);
      check_prop("gap43_b_nonconsec4", prop_nonconsec(4), 1'b1);
      check_prop("gap43_b_rep4", prop_consec(4), 1'b0);

      // Zero configuration treated as N=1, G=1: b@3, c@4, done@5.
      step(1, 1, 3'd0, 2'd0, 0);
      idle_cycles(8);
      check_prop("zero_cfg_nonconsec1", prop_nonconsec(1), 1'b1);

      // Second start and config change mid-run are ignored.
      step(1, 0, 3'd2, 2'd0, 0);
      step(0, 0, 3'd2, 2'd0, 0);
      step(1, 1, 3'd7, 2'd3, 0);
      idle_cycles(10);
      check_prop("ignore_restart_rep2", prop_consec(2), 1'b1);

      // start held high: next run accepted only in the IDLE cycle after DONE.
      for (int i = 0; i < 12; i++) step(1, 0, 3'd1, 2'd0, 0);
      idle_cycles(8);

      // Reset in cycle 4 of a CONSEC N=3 run, new start in cycle 6.
      step(1, 0, 3'd3, 2'd0, 0);
      idle_cycles(3);
      step(0, 0, 3'd3, 2'd0, 1);
      step(0, 0, 3'd3, 2'd0, 0);
      check_prop("abort_no_c", trace_done, 1'b0);
      step(1, 0, 3'd3, 2'd0, 0);
      idle_cycles(10);
      check_prop("post_reset_rep3", prop_consec(3), 1'b1);

      // A few random configurations.
      for (int r = 0; r < 4; r++) begin
         rmd = 1'($urandom_range(0, 1));
         rbc = 3'($urandom_range(0, 7));
         rgp = 2'($urandom_range(0, 3));
         step(1, rmd, rbc, rgp, 0);
         idle_cycles(34);
         check_prop("random_nonconsec", prop_nonconsec((rbc == 0) ? 1 : int'(rbc)), 1'b1);
      end

      vectors++;
      assert (sb.size() === 0) else begin
         miscompares++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rep_seq_gen.md
REP_SEQ_GEN -- requirements
Module: rep_seq_gen

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports clk and rst, all logic on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one a/b/c stimulus sequence; sampled only in IDLE.
REQ-005 mode  input  1  0 = CONSEC (back-to-back b), 1 = GAPPED (b pulses separated by idle cycles).
REQ-006 b_count  input  3  number of b pulses, 1..7; value 0 is treated as 1.
REQ-007 gap  input  2  idle cycles between b pulses in GAPPED mode, 1..3; value 0 is treated as 1.
REQ-008 a  output  1  trigger pulse; the checker-side $rose(a) event.
REQ-009 b  output  1  repeated-event signal.
REQ-010 c  output  1  terminating event.
REQ-011 busy  output  1  high from the cycle after start is accepted through the c cycle.
REQ-012 done  output  1  one-cycle pulse in the cycle after c.

Function
REQ-013 All outputs SHALL be registered; none SHALL depend combinationally on inputs.
REQ-014 mode, b_count and gap SHALL be latched at start acceptance; later input changes SHALL NOT affect the sequence in flight.
REQ-015 States: IDLE, A_PULSE, SETTLE, B_ON, B_GAP, C_PULSE, DONE.
REQ-016 Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE; cycle k is k clocks later.
REQ-017 A_PULSE (cycle 1): a=1 for exactly one cycle.
REQ-018 SETTLE (cycle 2): a=b=c=0.
REQ-019 The first b=1 SHALL occur in cycle 3, matching "$rose(a) |=> ##1 b...".
REQ-020 CONSEC: b=1 in cycles 3..2+N, where N is the effective b_count.
REQ-021 GAPPED: each b pulse SHALL be one cycle wide; consecutive pulses SHALL be separated by exactly G zero cycles (G = effective gap); last b in cycle 3+(N-1)(G+1).
REQ-022 c=1 for exactly one cycle, immediately after the last b cycle.
REQ-023 DONE: done=1 for one cycle after c, then return to IDLE; start may be accepted in that DONE cycle's following IDLE cycle at the earliest.
REQ-024 start while not IDLE SHALL be ignored, with no queuing.
REQ-025 a, b and c SHALL never be high in the same cycle.
REQ-026 The internal repetition and gap counters SHALL be 3 bits and 2 bits, down-counting, and SHALL never wrap.

Reset
REQ-027 rst=1 SHALL force IDLE with a=b=c=busy=done=0 and clear latched configuration and counters on the next edge.
REQ-028 rst asserted mid-sequence SHALL abort the sequence, with no c or done emitted afterwards.
REQ-029 The first start is honoured in the cycle after rst deasserts.

Structure
REQ-030 Package rep_seq_pkg SHALL hold the state enum, the mode enum (CONSEC/GAPPED) and the width constants (CNT_W=3, GAP_W=2).
REQ-031 Optional sub-module rep_seq_cnt SHALL be a loadable down-counter with a zero flag, instantiated for the b repetition count and for the gap count; there SHALL be no other hierarchy.
REQ-032 The bench SHALL bind assertions equivalent to the team's [*n], [=n] and [->m:n] repetition properties and require them to pass for matching configurations.

Verification
REQ-033 CONSEC, b_count=3, start in cycle 0 -> a@1; b@3,4,5; c@6; done@7; busy high in cycles 1..6.
REQ-034 GAPPED, b_count=2, gap=1 -> a@1; b@3,5; c@6; b[=2] and b[->2:4] properties pass, b[*3] property fails.
REQ-035 GAPPED, b_count=4, gap=3 -> b@3,7,11,15; c@16; done@17.
REQ-036 b_count=0, gap=0, GAPPED -> treated as N=1, G=1: b@3, c@4, done@5.
REQ-037 start pulsed in cycles 0 and 2, plus b_count changed in cycle 2 -> single sequence using the cycle-0 configuration.
REQ-038 rst asserted in cycle 4 of a CONSEC N=3 run -> all outputs 0 from cycle 5, no c or done; a new start in cycle 6 runs a full sequence.
